// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
//
// Pipeline hazard sequencer for a 5-stage RV32I core (F/D/X/M/W). It covers the
// hazards that operand forwarding cannot resolve:
//   - load-use: the load result is only usable once the load reaches W, so a
//     dependent instruction in D is held while bubbles are inserted into X
//   - taken branch/jump redirect resolved in X: the two younger stages are flushed
//   - data-memory wait: the whole front of the pipe is frozen and W gets bubbles
// It also keeps saturating counters of stall cycles and redirects.
//
// Parameters
//   LOAD_LAT    stall cycles needed with the load in X and its consumer in D (1..3)
//   CNT_W       width of the performance counters
//
// Ports
//   clk_i        clock
//   rst_i        synchronous reset, active-high
//   instD_i      instruction in D (0 = bubble)
//   instX_i      instruction in X
//   instM_i      instruction in M
//   pc_sel_i     taken branch/jump resolved in X this cycle
//   mem_busy_i   data memory not ready, M-stage access must be held
//   stall_F_o    hold PC
//   stall_D_o    hold the F/D register
//   stall_X_o    hold the D/X register
//   stall_M_o    hold the X/M register
//   flush_D_o    load a bubble into the F/D register
//   flush_X_o    load a bubble into the D/X register
//   flush_W_o    load a bubble into the M/W register
//   state_o      0 = RUN, 1 = LU_STALL, 2 = MEM_WAIT
//   stall_cnt_o  total stall cycles (saturating)
//   flush_cnt_o  total redirects (saturating)

module hazard_stall_controller #(
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      instD_i,
  input  logic [31:0]      instX_i,
  input  logic [31:0]      instM_i,
  input  logic             pc_sel_i,
  input  logic             mem_busy_i,
  output logic             stall_F_o,
  output logic             stall_D_o,
  output logic             stall_X_o,
  output logic             stall_M_o,
  output logic             flush_D_o,
  output logic             flush_X_o,
  output logic             flush_W_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpBType  = 7'b1100011;

  // Stall lengths for a consumer one and two instructions behind the load.
  localparam logic [1:0] NeedX = 2'(LOAD_LAT);
  localparam logic [1:0] NeedM = 2'(LOAD_LAT - 1);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLuStall = 2'd1,
    StMemWait = 2'd2
  } state_t;

  state_t           state_q;
  state_t           saved_q;   // state to resume when the memory wait ends
  logic [1:0]       lu_cnt_q;  // load-use stall cycles still to be output
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // ---------------------------------------------------------------------------
  // Instruction field decode
  // ---------------------------------------------------------------------------
  logic [6:0] op_d;
  logic [4:0] rs1_d;
  logic [4:0] rs2_d;
  logic [6:0] op_x;
  logic [4:0] rd_x;
  logic [6:0] op_m;
  logic [4:0] rd_m;

  assign op_d  = instD_i[6:0];
  assign rs1_d = instD_i[19:15];
  assign rs2_d = instD_i[24:20];
  assign op_x  = instX_i[6:0];
  assign rd_x  = instX_i[11:7];
  assign op_m  = instM_i[6:0];
  assign rd_m  = instM_i[11:7];

  // Fields that play no part in hazard detection.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{instD_i[31:25], instD_i[14:7], instX_i[31:12], instM_i[31:12]};

  logic use_rs1_d;
  logic use_rs2_d;
  logic load_x;
  logic load_m;
  logic dep_x;
  logic dep_m;

  // Store data is not a source here: the store-forward path covers it.
  assign use_rs1_d = (op_d != OpLui) && (op_d != OpAuipc) && (op_d != OpJal);
  assign use_rs2_d = (op_d == OpRType) || (op_d == OpBType);

  // rd != 0 on the load side keeps x0 from ever matching.
  assign load_x = (op_x == OpLoad) && (rd_x != 5'd0);
  assign load_m = (op_m == OpLoad) && (rd_m != 5'd0);

  assign dep_x = load_x && ((use_rs1_d && (rs1_d == rd_x)) || (use_rs2_d && (rs2_d == rd_x)));
  assign dep_m = load_m && ((use_rs1_d && (rs1_d == rd_m)) || (use_rs2_d && (rs2_d == rd_m)));

  // ---------------------------------------------------------------------------
  // Cycle action: memory wait > redirect > load-use
  // ---------------------------------------------------------------------------
  state_t     eff_state;
  logic       mem_hold;
  logic       lu_stall;
  logic       redirect;
  logic [1:0] need_n;
  logic       stall_cycle;

  // In the cycle mem_busy_i falls the register still says MEM_WAIT; behave as
  // the interrupted state so a pending load-use stall resumes immediately.
  assign eff_state = (state_q == StMemWait) ? saved_q : state_q;

  always_comb begin
    mem_hold = 1'b0;
    lu_stall = 1'b0;
    redirect = 1'b0;
    need_n   = 2'd0;
    if (!rst_i) begin
      if (mem_busy_i) begin
        mem_hold = 1'b1;
      end else if (eff_state == StLuStall) begin
        // X holds a bubble here, so pc_sel_i and new load-use are ignored.
        lu_stall = 1'b1;
      end else if (pc_sel_i) begin
        redirect = 1'b1;
      end else if (dep_x) begin
        need_n = NeedX;
      end else if (dep_m) begin
        need_n = NeedM;
      end
    end
  end

  assign stall_cycle = lu_stall || (need_n != 2'd0);

  assign stall_F_o = mem_hold || stall_cycle;
  assign stall_D_o = mem_hold || stall_cycle;
  assign stall_X_o = mem_hold;
  assign stall_M_o = mem_hold;
  assign flush_D_o = redirect;
  assign flush_X_o = redirect || stall_cycle;
  assign flush_W_o = mem_hold;

  // ---------------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StRun;
      saved_q     <= StRun;
      lu_cnt_q    <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (mem_hold) begin
        // Remember where we were only on entry; lu_cnt_q stays frozen.
        if (state_q != StMemWait) begin
          saved_q <= state_q;
        end
        state_q <= StMemWait;
      end else if (lu_stall) begin
        if (lu_cnt_q <= 2'd1) begin
          state_q  <= StRun;
          lu_cnt_q <= 2'd0;
        end else begin
          state_q  <= StLuStall;
          lu_cnt_q <= lu_cnt_q - 2'd1;
        end
      end else if (need_n > 2'd1) begin
        // The current cycle is the first stall; the rest come from LU_STALL.
        state_q  <= StLuStall;
        lu_cnt_q <= need_n - 2'd1;
      end else begin
        state_q <= StRun;
      end

      if ((mem_hold || stall_cycle) && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (redirect && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign state_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule
